video_text_buffer: RTL and testbench
====================================

Name: video_text_buffer

Overview:
- Parametrised character-cell buffer between the host/CPU writer and the VGA text renderer.
- Addressed by logical row/column instead of a flat address; display read port is registered.
- Adds a hardware clear-screen engine and a hardware scroll-up. Scroll uses a circular top-row offset plus an automatic blank of the new bottom row, so no data is copied.

Parameters:
- COLS, 80, character columns per row
- ROWS, 30, character rows; CELLS = COLS*ROWS is a localparam (2400 by default)
- DATA_W, 8, bits per character cell
- CW, $clog2(COLS), column index width (derived)
- RW, $clog2(ROWS), row index width (derived)

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe
- wr_row  in  RW  logical row of write
- wr_col  in  CW  column of write
- wr_data  in  DATA_W  character to write
- wr_ready  out  1  = !busy; a write takes effect only when wr_en && wr_ready
- rd_row  in  RW  logical row requested by renderer
- rd_col  in  CW  column requested by renderer
- rd_data  out  DATA_W  registered read data
- cmd_clear  in  1  single-cycle request: fill all cells with fill_char
- cmd_scroll  in  1  single-cycle request: scroll up one row
- fill_char  in  DATA_W  blank value used by clear and scroll; sampled when a command is accepted
- busy  out  1  engine active
- top_row  out  RW  current physical row shown as logical row 0 (debug/status)

Behaviour:
- Reset (async, rst_n=0): rd_data=0, busy=0, top_row=0, state=IDLE, counters=0. RAM contents are not reset.
- Address translation: phys_row = row+top_row, minus ROWS if the sum >= ROWS (no modulo operator). addr = phys_row*COLS + col.
- Read port: rd_data is valid 1 cycle after rd_row/rd_col are sampled, and is never stalled by busy.
  - Same-cell read and write in one cycle returns the old data (read-first).
  - row>=ROWS or col>=COLS returns 0.
- Write port: out-of-range coordinates are ignored. Writes are dropped while busy (wr_ready=0); the host must hold them.
- Commands are accepted only in IDLE. Requests made while busy are ignored, not queued. If both are asserted together, clear wins and the scroll is dropped.
- FSM states: IDLE, CLEAR, SCROLL.
  - IDLE -> CLEAR on cmd_clear. Latch fill_char, set cnt=0, set top_row=0 on the accept edge.
  - CLEAR: write fill to physical address cnt each cycle for cnt=0..CELLS-1; return to IDLE after cnt=CELLS-1.
  - IDLE -> SCROLL on cmd_scroll. Latch fill_char, set fill_row=top_row (old value), set top_row=top_row+1 wrapping ROWS-1->0, set cnt=0.
  - SCROLL: write fill to physical (fill_row, cnt) for cnt=0..COLS-1; return to IDLE after cnt=COLS-1.
- Timing: command sampled at edge N. busy=1 after edge N. Engine writes at edges N+1..N+L, where L=CELLS (clear) or COLS (scroll). busy=0 after edge N+L. Next command accepted at edge N+L+1 at the earliest.
- top_row changes at the accept edge, so display reads are already shifted during the blanking. The new bottom row may briefly show stale text; this is acceptable.
- Async reset mid-operation aborts the engine. Buffer contents are partially cleared; top_row returns to 0.

Optional Feature:
- Macro VIDEO_TEXT_ATTR_EN, defined: adds an attribute plane.
  - Parameter ATTR_W (default 8).
  - Ports wr_attr(in), fill_attr(in), rd_attr(out, same 1-cycle latency, reset 0).
  - Clear and scroll fill both planes.
- Undefined: these ports and the parameter are absent; character plane only.

Decomposition:
- Package video_text_pkg holds:
  - default COLS/ROWS/DATA_W/ATTR_W constants
  - FSM state typedef (IDLE/CLEAR/SCROLL)
- Sub-module video_text_mem: parametrised 1-write/1-read synchronous RAM (DEPTH, WIDTH), read-first, registered output. Instantiated once per plane.

Test Plan:
- Reset then write 'A'(0x41) at (0,0) and 'Z'(0x5A) at (29,79); read both -> rd_data 0x41 and 0x5A exactly 1 cycle after address.
- cmd_clear with fill_char=0x20 -> busy high for exactly 2400 cycles; wr_en during busy leaves the cell unchanged; afterwards every cell reads 0x20 and top_row=0.
- Write row index into col 0 of each row, then cmd_scroll, fill 0x20 -> busy for 80 cycles, top_row=1; (0,0) reads 1, (28,0) reads 29, (29,0) reads 0x20.
- 30 consecutive scrolls -> top_row wraps 29->0; logical addressing remains correct at the wrap.
- cmd_clear and cmd_scroll in the same cycle -> clear runs (2400-cycle busy), no scroll. cmd_scroll while busy -> ignored.
- Deassert rst_n at clear cycle 100 -> busy=0, rd_data=0, top_row=0 immediately; a new cmd_clear after release completes normally.

Source files
------------

// File: rtl/video_text_pkg.sv
// Shared defaults and engine state encoding for the character-cell text buffer.
package video_text_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ATTR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } vt_state_t;

endpackage

// File: rtl/video_text_mem.sv
// Purpose: 1-write/1-read synchronous RAM, read-first, registered output (0 when rd_ok low).
// Latency: rdata valid 1 cycle after raddr. Backpressure: none, both ports accept every cycle.
module video_text_mem #(
  parameter int DEPTH = 2400,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_ok,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reading the array in the same edge as the write gives the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= rd_ok ? mem[raddr] : '0;
  end

endmodule

// File: rtl/video_text_buffer.sv
// Purpose: row/column text buffer with clear and circular scroll-up engines (VIDEO_TEXT_ATTR_EN adds attr plane).
// Latency: rd_data 1 cycle after rd_row/rd_col; clear busy CELLS cycles, scroll busy COLS cycles.
// Backpressure: wr_ready = !busy; writes and commands arriving while busy are dropped, never queued.
module video_text_buffer
  import video_text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W,
`ifdef VIDEO_TEXT_ATTR_EN
  parameter int ATTR_W = DEF_ATTR_W,
`endif
  parameter int CW     = $clog2(COLS),
  parameter int RW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data,
`ifdef VIDEO_TEXT_ATTR_EN
  input  logic [ATTR_W-1:0] wr_attr,
  input  logic [ATTR_W-1:0] fill_attr,
  output logic [ATTR_W-1:0] rd_attr,
`endif
  input  logic              cmd_clear,
  input  logic              cmd_scroll,
  input  logic [DATA_W-1:0] fill_char,
  output logic              busy,
  output logic [RW-1:0]     top_row
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  vt_state_t         state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [RW-1:0]     top_nxt, fill_row, fill_row_nxt;
  logic [DATA_W-1:0] fill_q, fill_nxt;
  logic              eng_we;
  logic [AW-1:0]     eng_addr;

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] top);
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (32'(s) >= ROWS) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [CW-1:0] c);
    return AW'(pr) * AW'(COLS) + AW'(c);
  endfunction

  logic          wr_ok, rd_ok, mem_we;
  logic [AW-1:0] wr_addr, rd_addr, mem_waddr;

  assign busy     = (state != IDLE);
  assign wr_ready = !busy;
  assign wr_ok    = wr_en && !busy && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign rd_ok    = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign wr_addr  = cell_addr(phys_row(wr_row, top_row), wr_col);
  assign rd_addr  = cell_addr(phys_row(rd_row, top_row), rd_col);

  // Engine writes only happen while busy, so they never collide with host writes.
  assign mem_we    = eng_we || wr_ok;
  assign mem_waddr = eng_we ? eng_addr : wr_addr;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    top_nxt      = top_row;
    fill_row_nxt = fill_row;
    fill_nxt     = fill_q;
    eng_we       = 1'b0;
    eng_addr     = cnt;
    case (state)
      IDLE: begin
        if (cmd_clear) begin
          state_nxt = CLEAR;
          fill_nxt  = fill_char;
          cnt_nxt   = '0;
          top_nxt   = '0;
        end else if (cmd_scroll) begin
          state_nxt    = SCROLL;
          fill_nxt     = fill_char;
          fill_row_nxt = top_row;
          top_nxt      = (32'(top_row) == ROWS - 1) ? '0 : top_row + RW'(1);
          cnt_nxt      = '0;
        end
      end
      CLEAR: begin
        eng_we   = 1'b1;
        eng_addr = cnt;
        if (32'(cnt) == CELLS - 1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      SCROLL: begin
        eng_we   = 1'b1;
        eng_addr = cell_addr(fill_row, CW'(cnt));
        if (32'(cnt) == COLS - 1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      top_row  <= '0;
      fill_row <= '0;
      fill_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      top_row  <= top_nxt;
      fill_row <= fill_row_nxt;
      fill_q   <= fill_nxt;
    end
  end

  video_text_mem #(.DEPTH(CELLS), .WIDTH(DATA_W), .AW(AW)) u_char_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (eng_we ? fill_q : wr_data),
    .rd_ok (rd_ok),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef VIDEO_TEXT_ATTR_EN
  logic [ATTR_W-1:0] fill_attr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        fill_attr_q <= '0;
    else if (state == IDLE && (cmd_clear || cmd_scroll)) fill_attr_q <= fill_attr;
  end

  video_text_mem #(.DEPTH(CELLS), .WIDTH(ATTR_W), .AW(AW)) u_attr_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (eng_we ? fill_attr_q : wr_attr),
    .rd_ok (rd_ok),
    .raddr (rd_addr),
    .rdata (rd_attr)
  );
`endif

endmodule

// File: tb/tb_video_text_buffer.sv
// Self-checking bench: random host traffic and commands against a logical-screen model.
module tb_video_text_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CW   = 7;
  localparam int RW   = 5;

  logic          clk, rst_n;
  logic          wr_en, wr_ready, cmd_clear, cmd_scroll, busy;
  logic [RW-1:0] wr_row, rd_row, top_row;
  logic [CW-1:0] wr_col, rd_col;
  logic [7:0]    wr_data, rd_data, fill_char;
`ifdef VIDEO_TEXT_ATTR_EN
  logic [7:0]    wr_attr, fill_attr, rd_attr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Logical screen as the host sees it; scroll physically shifts rows here.
  logic [7:0] scr   [ROWS][COLS];
  bit         known [ROWS][COLS];
  int         mtop;

  video_text_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
`ifdef VIDEO_TEXT_ATTR_EN
    .wr_attr(wr_attr), .fill_attr(fill_attr), .rd_attr(rd_attr),
`endif
    .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .fill_char(fill_char),
    .busy(busy), .top_row(top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_forget();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) known[r][c] = 1'b0;
    mtop = 0;
  endfunction

  function automatic void m_clear(input logic [7:0] f);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        scr[r][c] = f;
        known[r][c] = 1'b1;
      end
    mtop = 0;
  endfunction

  function automatic void m_scroll(input logic [7:0] f);
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) begin
        scr[r][c] = scr[r+1][c];
        known[r][c] = known[r+1][c];
      end
    for (int c = 0; c < COLS; c++) begin
      scr[ROWS-1][c] = f;
      known[ROWS-1][c] = 1'b1;
    end
    mtop = (mtop + 1) % ROWS;
  endfunction

  task automatic do_write(input int r, input int c, input logic [7:0] d);
    wr_row = RW'(r); wr_col = CW'(c); wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) begin
      scr[r][c] = d;
      known[r][c] = 1'b1;
    end
  endtask

  task automatic do_read(input int r, input int c, output logic [7:0] d);
    rd_row = RW'(r); rd_col = CW'(c);
    tick();
    d = rd_data;
  endtask

  task automatic run_cmd(input logic clr, input logic scl, input logic [7:0] f, output int len);
    cmd_clear = clr; cmd_scroll = scl; fill_char = f;
    tick();
    cmd_clear = 1'b0; cmd_scroll = 1'b0;
    len = 0;
    while (busy === 1'b1 && len < 6000) begin
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 0; cmd_clear = 0; cmd_scroll = 0;
    wr_row = 0; wr_col = 0; wr_data = 0; rd_row = 0; rd_col = 0; fill_char = 0;
`ifdef VIDEO_TEXT_ATTR_EN
    wr_attr = 0; fill_attr = 0;
`endif
    m_forget();
    #3;
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (rd_data !== 8'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL reset_top_row got %0d want 0", top_row); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    #20 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    do_write(0, 0, 8'h41);
    do_write(29, 79, 8'h5A);
    do_read(0, 0, d);
    n_cmp++; if (d !== 8'h41) begin n_bad++; $display("FAIL rd_0_0 got %h want 41", d); end
    do_read(29, 79, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL rd_29_79 got %h want 5a", d); end
    // Out-of-range column must not alias into the next row.
    do_write(1, 0, 8'h33);
    do_write(0, 100, 8'hEE);
    do_read(1, 0, d);
    n_cmp++; if (d !== 8'h33) begin n_bad++; $display("FAIL oor_write_alias got %h want 33", d); end
    do_read(31, 0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL oor_row_read got %h want 00", d); end
    do_read(0, 90, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL oor_col_read got %h want 00", d); end
    // Same-cell read and write in one cycle: old data first, new data next.
    do_write(3, 7, 8'h11);
    rd_row = 5'd3; rd_col = 7'd7;
    do_write(3, 7, 8'h99);
    n_cmp++; if (rd_data !== 8'h11) begin n_bad++; $display("FAIL read_first got %h want 11", rd_data); end
    tick();
    n_cmp++; if (rd_data !== 8'h99) begin n_bad++; $display("FAIL read_after_write got %h want 99", rd_data); end
  endtask

  task automatic test_random_rw(input int n);
    logic [7:0] d;
    int r, c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(ROWS - 1); c = $urandom_range(COLS - 1);
      if ($urandom_range(1) == 0) begin
        do_write(r, c, 8'($urandom));
      end else begin
        do_read(r, c, d);
        if (known[r][c]) begin
          n_cmp++;
          if (d !== scr[r][c]) begin n_bad++; $display("FAIL rand_read(%0d,%0d) got %h want %h", r, c, d, scr[r][c]); end
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [7:0] d;
    int len;
    cmd_clear = 1'b1; fill_char = 8'h20;
    tick();
    cmd_clear = 1'b0;
    len = 0;
    while (busy === 1'b1 && len < 6000) begin
      if (len == 2390) begin
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clear_wr_ready got %b want 0", wr_ready); end
        wr_row = 0; wr_col = 0; wr_data = 8'h77; wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      len++;
      tick();
    end
    wr_en = 1'b0;
    m_clear(8'h20);
    n_cmp++; if (len != ROWS * COLS) begin n_bad++; $display("FAIL clear_busy_len got %0d want %0d", len, ROWS * COLS); end
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL clear_top_row got %0d want 0", top_row); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        do_read(r, c, d);
        n_cmp++;
        if (d !== scr[r][c]) begin n_bad++; $display("FAIL clear_cell(%0d,%0d) got %h want %h", r, c, d, scr[r][c]); end
      end
  endtask

  task automatic test_scroll();
    logic [7:0] d;
    int len;
    for (int r = 0; r < ROWS; r++) do_write(r, 0, 8'(r));
    test_random_rw(40);
    run_cmd(1'b0, 1'b1, 8'h20, len);
    m_scroll(8'h20);
    n_cmp++; if (len != COLS) begin n_bad++; $display("FAIL scroll_busy_len got %0d want %0d", len, COLS); end
    n_cmp++; if (top_row !== 5'd1) begin n_bad++; $display("FAIL scroll_top_row got %0d want 1", top_row); end
    do_read(0, 0, d);
    n_cmp++; if (d !== 8'd1) begin n_bad++; $display("FAIL scroll_rd_0_0 got %h want 01", d); end
    do_read(28, 0, d);
    n_cmp++; if (d !== 8'd29) begin n_bad++; $display("FAIL scroll_rd_28_0 got %h want 1d", d); end
    do_read(29, 0, d);
    n_cmp++; if (d !== 8'h20) begin n_bad++; $display("FAIL scroll_rd_29_0 got %h want 20", d); end
    test_random_rw(60);
  endtask

  task automatic test_scroll_wrap();
    logic [7:0] f;
    int len;
    for (int k = 0; k < ROWS - 1; k++) begin
      f = 8'($urandom);
      run_cmd(1'b0, 1'b1, f, len);
      m_scroll(f);
      n_cmp++; if (len != COLS) begin n_bad++; $display("FAIL wrap_busy_len[%0d] got %0d want %0d", k, len, COLS); end
      n_cmp++; if (int'(top_row) != mtop) begin n_bad++; $display("FAIL wrap_top_row[%0d] got %0d want %0d", k, top_row, mtop); end
      test_random_rw(8);
    end
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL wrap_final_top got %0d want 0", top_row); end
    test_random_rw(80);
  endtask

  task automatic test_clear_wins();
    logic [7:0] d;
    int len;
    run_cmd(1'b0, 1'b1, 8'h2D, len);
    m_scroll(8'h2D);
    n_cmp++; if (int'(top_row) != mtop) begin n_bad++; $display("FAIL pre_top_row got %0d want %0d", top_row, mtop); end
    cmd_clear = 1'b1; cmd_scroll = 1'b1; fill_char = 8'h2E;
    tick();
    cmd_clear = 1'b0; cmd_scroll = 1'b0;
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL both_top_row got %0d want 0", top_row); end
    len = 0;
    while (busy === 1'b1 && len < 6000) begin
      cmd_scroll = (len == 50);
      fill_char = (len == 50) ? 8'h55 : 8'h2E;
      len++;
      tick();
    end
    cmd_scroll = 1'b0;
    m_clear(8'h2E);
    n_cmp++; if (len != ROWS * COLS) begin n_bad++; $display("FAIL both_busy_len got %0d want %0d", len, ROWS * COLS); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_scroll_queued got %b want 0", busy); end
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL busy_scroll_top got %0d want 0", top_row); end
    do_read(ROWS - 1, 5, d);
    n_cmp++; if (d !== 8'h2E) begin n_bad++; $display("FAIL both_bottom_cell got %h want 2e", d); end
    test_random_rw(60);
  endtask

  task automatic test_reset_mid();
    int len;
    // Reset during a scroll drops top_row back to 0.
    cmd_scroll = 1'b1; fill_char = 8'h23;
    tick();
    cmd_scroll = 1'b0;
    repeat (40) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL scroll_rst_top got %0d want 0", top_row); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL scroll_rst_busy got %b want 0", busy); end
    #10 rst_n = 1'b1;
    m_forget();
    tick();
    // Reset 100 cycles into a clear.
    rd_row = 0; rd_col = 0;
    cmd_clear = 1'b1; fill_char = 8'h41;
    tick();
    cmd_clear = 1'b0;
    repeat (100) tick();
    n_cmp++; if (rd_data !== 8'h41) begin n_bad++; $display("FAIL mid_clear_rd got %h want 41", rd_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_cmp++; if (rd_data !== 8'h0) begin n_bad++; $display("FAIL mid_rst_rd_data got %h want 00", rd_data); end
    n_cmp++; if (top_row !== 5'd0) begin n_bad++; $display("FAIL mid_rst_top got %0d want 0", top_row); end
    #10 rst_n = 1'b1;
    tick();
    run_cmd(1'b1, 1'b0, 8'h5F, len);
    m_clear(8'h5F);
    n_cmp++; if (len != ROWS * COLS) begin n_bad++; $display("FAIL post_rst_clear_len got %0d want %0d", len, ROWS * COLS); end
    test_random_rw(80);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_random_rw(100);
    test_clear();
    test_scroll();
    test_scroll_wrap();
    test_clear_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
